// File: rtl/tlb_refill_ctrl_pkg.sv
// rtl/tlb_refill_ctrl_pkg.sv - shared geometry, field widths and FSM states for the TLB refill controller
package tlb_refill_ctrl_pkg;
  localparam int NUM_SETS       = 16;
  localparam int NUM_WAYS       = 4;
  localparam int SET_INDEX_BITS = 4;
  localparam int LRU_BITS       = 4;
  localparam int WAY_BITS       = 2;
  localparam int VPN_W          = 20;
  localparam int PPN_W          = 20;
  localparam int PERM_W         = 2;
  localparam logic [LRU_BITS-1:0] LRU_MAX = {LRU_BITS{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_SEL  = 3'd2,
    S_WR   = 3'd3,
    S_AGE  = 3'd4,
    S_DONE = 3'd5
  } refill_state_t;
endpackage

// File: rtl/tlb_victim_sel.sv
// rtl/tlb_victim_sel.sv - combinational victim choice: hit way, else lowest invalid way, else oldest way
module tlb_victim_sel
  import tlb_refill_ctrl_pkg::*;
(
  input  logic [NUM_WAYS-1:0]          valid,
  input  logic [NUM_WAYS*VPN_W-1:0]    vpns,
  input  logic [NUM_WAYS*LRU_BITS-1:0] lru,
  input  logic [VPN_W-1:0]             req_vpn,
  output logic [WAY_BITS-1:0]          way,
  output logic                         hit,
  output logic                         evict,
  output logic [VPN_W-1:0]             evict_vpn
);
  logic                hit_any, inv_any;
  logic [WAY_BITS-1:0] hit_way, inv_way, old_way;
  logic [LRU_BITS-1:0] old_cnt;

  always_comb begin
    hit_any = 1'b0;
    inv_any = 1'b0;
    hit_way = '0;
    inv_way = '0;
    old_way = '0;
    old_cnt = lru[0 +: LRU_BITS];
    // Descending scans leave the lowest qualifying index as the winner.
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid[w] && vpns[VPN_W*w +: VPN_W] == req_vpn) begin
        hit_any = 1'b1;
        hit_way = WAY_BITS'(w);
      end
      if (!valid[w]) begin
        inv_any = 1'b1;
        inv_way = WAY_BITS'(w);
      end
    end
    // Strict compare keeps the lowest index on equal ages.
    for (int w = 1; w < NUM_WAYS; w++) begin
      if (lru[LRU_BITS*w +: LRU_BITS] > old_cnt) begin
        old_cnt = lru[LRU_BITS*w +: LRU_BITS];
        old_way = WAY_BITS'(w);
      end
    end
    hit       = hit_any;
    way       = hit_any ? hit_way : (inv_any ? inv_way : old_way);
    evict     = !hit_any && !inv_any;
    evict_vpn = evict ? vpns[VPN_W*way +: VPN_W] : '0;
  end
endmodule

// File: rtl/tlb_refill_ctrl.sv
// rtl/tlb_refill_ctrl.sv - installs walker refills into tlb_storage and ages the remaining ways
// Optional TLB_REFILL_STATS_EN adds saturating refill/evict counters.
module tlb_refill_ctrl
  import tlb_refill_ctrl_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [VPN_W-1:0]             req_vpn,
  input  logic [PPN_W-1:0]             req_ppn,
  input  logic [PERM_W-1:0]            req_perms,
  output logic [SET_INDEX_BITS-1:0]    rd_set_index,
  input  logic [NUM_WAYS-1:0]          rd_valid,
  input  logic [NUM_WAYS*VPN_W-1:0]    rd_vpn,
  input  logic [NUM_WAYS*LRU_BITS-1:0] rd_lru_count,
  output logic                         wr_en,
  output logic [SET_INDEX_BITS-1:0]    wr_set_index,
  output logic [WAY_BITS-1:0]          wr_way,
  output logic                         wr_valid,
  output logic [VPN_W-1:0]             wr_vpn,
  output logic [PPN_W-1:0]             wr_ppn,
  output logic [PERM_W-1:0]            wr_perms,
  output logic [LRU_BITS-1:0]          wr_lru_count,
  output logic                         lru_update_en,
  output logic [SET_INDEX_BITS-1:0]    lru_set_index,
  output logic [WAY_BITS-1:0]          lru_way,
  output logic [LRU_BITS-1:0]          lru_value,
  output logic                         done_valid,
  output logic [WAY_BITS-1:0]          done_way,
  output logic                         done_evict,
  output logic [VPN_W-1:0]             done_evict_vpn
`ifdef TLB_REFILL_STATS_EN
  ,
  output logic [15:0]                  stat_refills,
  output logic [15:0]                  stat_evicts
`endif
);
  refill_state_t               state;
  logic [VPN_W-1:0]            lat_vpn;
  logic [PPN_W-1:0]            lat_ppn;
  logic [PERM_W-1:0]           lat_perms;
  logic [NUM_WAYS-1:0]         s_valid;
  logic [NUM_WAYS*VPN_W-1:0]   s_vpn;
  logic [NUM_WAYS*LRU_BITS-1:0] s_lru;
  logic [WAY_BITS-1:0]         victim, age_k, next_k;
  logic                        evict_q;
  logic [VPN_W-1:0]            evict_vpn_q;
  logic [WAY_BITS-1:0]         sel_way;
  logic                        sel_hit, sel_evict;
  logic [VPN_W-1:0]            sel_evict_vpn;
  logic [LRU_BITS-1:0]         nk_cnt;
  logic                        nk_en;

  tlb_victim_sel u_victim_sel (
    .valid     (s_valid),
    .vpns      (s_vpn),
    .lru       (s_lru),
    .req_vpn   (lat_vpn),
    .way       (sel_way),
    .hit       (sel_hit),
    .evict     (sel_evict),
    .evict_vpn (sel_evict_vpn)
  );

  // Way whose age update is presented on the LRU port next cycle.
  always_comb begin
    next_k = (state == S_WR) ? '0 : age_k + 1'b1;
    nk_cnt = s_lru[LRU_BITS*next_k +: LRU_BITS];
    nk_en  = s_valid[next_k] && (next_k != victim) && (nk_cnt != LRU_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      req_ready <= 1'b1;
      lat_vpn <= '0; lat_ppn <= '0; lat_perms <= '0;
      s_valid <= '0; s_vpn <= '0; s_lru <= '0;
      victim <= '0; age_k <= '0; evict_q <= 1'b0; evict_vpn_q <= '0;
      rd_set_index <= '0;
      wr_en <= 1'b0; wr_set_index <= '0; wr_way <= '0; wr_valid <= 1'b0;
      wr_vpn <= '0; wr_ppn <= '0; wr_perms <= '0; wr_lru_count <= '0;
      lru_update_en <= 1'b0; lru_set_index <= '0; lru_way <= '0; lru_value <= '0;
      done_valid <= 1'b0; done_way <= '0; done_evict <= 1'b0; done_evict_vpn <= '0;
`ifdef TLB_REFILL_STATS_EN
      stat_refills <= '0;
      stat_evicts <= '0;
`endif
    end else begin
      wr_en <= 1'b0;
      lru_update_en <= 1'b0;
      done_valid <= 1'b0;
      case (state)
        S_IDLE: if (req_valid && req_ready) begin
          lat_vpn <= req_vpn;
          lat_ppn <= req_ppn;
          lat_perms <= req_perms;
          rd_set_index <= req_vpn[SET_INDEX_BITS-1:0];
          req_ready <= 1'b0;
          state <= S_RD;
        end
        S_RD: begin
          s_valid <= rd_valid;
          s_vpn <= rd_vpn;
          s_lru <= rd_lru_count;
          state <= S_SEL;
        end
        S_SEL: begin
          victim <= sel_way;
          evict_q <= sel_evict;
          evict_vpn_q <= sel_evict_vpn;
          wr_en <= 1'b1;
          wr_set_index <= rd_set_index;
          wr_way <= sel_way;
          wr_valid <= 1'b1;
          wr_vpn <= lat_vpn;
          wr_ppn <= lat_ppn;
          wr_perms <= lat_perms;
          wr_lru_count <= '0;
          state <= S_WR;
        end
        S_WR, S_AGE: begin
          if (state == S_AGE && age_k == WAY_BITS'(NUM_WAYS - 1)) begin
            done_valid <= 1'b1;
            done_way <= victim;
            done_evict <= evict_q;
            done_evict_vpn <= evict_vpn_q;
            state <= S_DONE;
          end else begin
            age_k <= next_k;
            lru_update_en <= nk_en;
            lru_set_index <= rd_set_index;
            lru_way <= next_k;
            lru_value <= nk_cnt + 1'b1;
            state <= S_AGE;
          end
        end
        S_DONE: begin
`ifdef TLB_REFILL_STATS_EN
          if (stat_refills != 16'hFFFF) stat_refills <= stat_refills + 16'd1;
          if (done_evict && stat_evicts != 16'hFFFF) stat_evicts <= stat_evicts + 16'd1;
`endif
          req_ready <= 1'b1;
          state <= S_IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

  logic unused_hit;
  assign unused_hit = sel_hit;
endmodule
